// File: rtl/game_input_pkg.sv
// Shared constants for the game input block: button indices, debounce
// state encoding and default timing parameters.
package GamePkg;

  localparam int NUM_BTN    = 7;
  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_JUMP   = 2;
  localparam int BTN_SQUAT  = 3;
  localparam int BTN_ATTACK = 4;
  localparam int BTN_DEFEND = 5;
  localparam int BTN_SELECT = 6;

  localparam int DEB_CYCLES_DEF = 500000;
  localparam int CD_CYCLES_DEF  = 25000000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } deb_state_t;

endpackage

// File: rtl/game_input_btn_debounce.sv
// Single-button synchronizer + debounce FSM. The first sync flop captures the
// inverted raw pin so a cleared flop always reads as "not pressed".
module btn_debounce
  import GamePkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    sync;
  logic          hi;
  deb_state_t    state;
  logic [CW-1:0] cnt;

  assign hi    = sync[1];
  assign level = (state == HELD) || (state == REL_WAIT);

  // The transition-into-wait cycle already counts as the first stable cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], ~btn_n};
      case (state)
        IDLE: if (hi) begin
          state <= PRESS_WAIT;
          cnt   <= CNT_ONE;
        end
        PRESS_WAIT: begin
          if (!hi) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: if (!hi) begin
          state <= REL_WAIT;
          cnt   <= CNT_ONE;
        end
        REL_WAIT: begin
          if (hi) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/game_input.sv
// Game controller input front end: per-button debounce, hold-level gating and
// press pulses. Define GAME_INPUT_ATTACK_COOLDOWN_EN to rate-limit o_attack.
module game_input
  import GamePkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CD_CYCLES  = CD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_btn_n,
  input  logic       i_is_gaming,
  output logic       o_right,
  output logic       o_left,
  output logic       o_squat,
  output logic       o_defend,
  output logic       o_jump,
  output logic       o_attack,
  output logic       o_select
);

  logic [NUM_BTN-1:0] lvl;
  logic [2:0]         plvl, plvl_q, rise;
  logic               atk_ok, atk_fire;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (i_btn_n[g]),
      .level (lvl[g])
    );
  end

  // Opposing directions cancel rather than picking a winner.
  assign o_right  = lvl[BTN_RIGHT] & ~lvl[BTN_LEFT] & i_is_gaming;
  assign o_left   = lvl[BTN_LEFT] & ~lvl[BTN_RIGHT] & i_is_gaming;
  assign o_squat  = lvl[BTN_SQUAT] & i_is_gaming;
  assign o_defend = lvl[BTN_DEFEND] & i_is_gaming;

  // Edge history tracks every cycle so edges seen while not gaming are consumed.
  assign plvl     = {lvl[BTN_SELECT], lvl[BTN_ATTACK], lvl[BTN_JUMP]};
  assign rise     = plvl & ~plvl_q;
  assign atk_fire = rise[1] & i_is_gaming & atk_ok;

`ifdef GAME_INPUT_ATTACK_COOLDOWN_EN
  localparam int CDW = $clog2(CD_CYCLES + 1);
  logic [CDW-1:0] cd_cnt;

  assign atk_ok = (cd_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cd_cnt <= '0;
    else if (!i_is_gaming)   cd_cnt <= '0;
    else if (atk_fire)       cd_cnt <= CDW'(CD_CYCLES - 1);
    else if (cd_cnt != '0)   cd_cnt <= cd_cnt - 1'b1;
  end
`else
  assign atk_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plvl_q   <= '0;
      o_jump   <= 1'b0;
      o_attack <= 1'b0;
      o_select <= 1'b0;
    end else begin
      plvl_q   <= plvl;
      o_jump   <= rise[0] & i_is_gaming;
      o_attack <= atk_fire;
      o_select <= rise[2];
    end
  end

endmodule

// File: tb/tb_game_input.sv
// Directed bench for game_input with DEB_CYCLES=4, CD_CYCLES=10.
module tb_game_input;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] i_btn_n;
  logic       i_is_gaming;
  logic       o_right, o_left, o_squat, o_defend, o_jump, o_attack, o_select;

  game_input #(.DEB_CYCLES(4), .CD_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .i_btn_n(i_btn_n), .i_is_gaming(i_is_gaming),
    .o_right(o_right), .o_left(o_left), .o_squat(o_squat), .o_defend(o_defend),
    .o_jump(o_jump), .o_attack(o_attack), .o_select(o_select)
  );

  always #5 clk = ~clk;

`ifdef GAME_INPUT_ATTACK_COOLDOWN_EN
  localparam int EXP_CD_P1 = 1;
`else
  localparam int EXP_CD_P1 = 2;
`endif

  typedef struct {
    logic [6:0] btn_n;
    logic       gaming;
    logic       r, l, sq, df;
    int         nj, na, ns;
  } vec_t;

  vec_t vecs[11];
  int total = 0, bad = 0;
  int pj, pa, ps, fj, fa, fs, ncyc;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    pj = 0; pa = 0; ps = 0; fj = -1; fa = -1; fs = -1; ncyc = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ncyc++;
      if (o_jump)   begin pj++; if (fj < 0) fj = ncyc; end
      if (o_attack) begin pa++; if (fa < 0) fa = ncyc; end
      if (o_select) begin ps++; if (fs < 0) fs = ncyc; end
    end
  endtask

  initial begin
    //            btn_n        g     r     l     sq    df    nj na ns
    vecs[0]  = '{7'b1111110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[1]  = '{7'b1111100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[2]  = '{7'b1111101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    vecs[3]  = '{7'b1010111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0};
    vecs[4]  = '{7'b1010111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[5]  = '{7'b0010011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1};
    vecs[6]  = '{7'b0010011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0};
    vecs[7]  = '{7'b1111111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[8]  = '{7'b0101011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1};
    vecs[9]  = '{7'b0101011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[10] = '{7'b1111111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};

    // Reset with every button pressed: all outputs must stay low.
    rst_n = 1'b0; i_btn_n = 7'b0000000; i_is_gaming = 1'b1;
    clr();
    run(3);
    check("rst o_right", int'(o_right), 0);
    check("rst o_left", int'(o_left), 0);
    check("rst o_squat", int'(o_squat), 0);
    check("rst o_defend", int'(o_defend), 0);
    check("rst pulses", pj + pa + ps, 0);
    i_btn_n = 7'h7F;
    run(2);
    rst_n = 1'b1;
    run(4);

    // Clean jump press: one pulse, 7 cycles after the press.
    clr(); i_btn_n = 7'b1111011;
    run(20);
    check("jump count", pj, 1);
    check("jump latency", fj, 7);
    clr(); i_btn_n = 7'h7F;
    run(12);
    check("jump release", pj, 0);

    foreach (vecs[k]) begin
      i_btn_n = vecs[k].btn_n; i_is_gaming = vecs[k].gaming;
      clr();
      run(12);
      check($sformatf("vec%0d o_right", k), int'(o_right), int'(vecs[k].r));
      check($sformatf("vec%0d o_left", k), int'(o_left), int'(vecs[k].l));
      check($sformatf("vec%0d o_squat", k), int'(o_squat), int'(vecs[k].sq));
      check($sformatf("vec%0d o_defend", k), int'(o_defend), int'(vecs[k].df));
      check($sformatf("vec%0d jumps", k), pj, vecs[k].nj);
      check($sformatf("vec%0d attacks", k), pa, vecs[k].na);
      check($sformatf("vec%0d selects", k), ps, vecs[k].ns);
    end

    // Bounce on attack: 2-cycle toggles never survive debounce.
    clr();
    for (int b = 0; b < 3; b++) begin
      i_btn_n = 7'b1101111; run(2);
      i_btn_n = 7'h7F;      run(2);
    end
    check("bounce quiet", pa, 0);
    i_btn_n = 7'b1101111;
    run(20);
    check("bounce count", pa, 1);
    check("bounce latency", fa, 19);
    i_btn_n = 7'h7F;
    run(20);

    // Conflict release: o_right follows left's release after exactly 6 cycles.
    i_btn_n = 7'b1111100;
    run(12);
    check("conflict r", int'(o_right), 0);
    i_btn_n = 7'b1111110;
    run(5);
    check("conflict r@5", int'(o_right), 0);
    run(1);
    check("conflict r@6", int'(o_right), 1);
    i_btn_n = 7'h7F;
    run(12);

    // Cooldown: second press lands while the counter is still nonzero.
    clr();
    i_btn_n = 7'b1101111; run(4);
    i_btn_n = 7'h7F;      run(4);
    i_btn_n = 7'b1101111; run(12);
    i_btn_n = 7'h7F;      run(30);
    check("cd first latency", fa, 7);
    check("cd pair count", pa, EXP_CD_P1);
    clr();
    i_btn_n = 7'b1101111; run(12);
    check("cd third count", pa, 1);
    i_btn_n = 7'h7F;
    run(12);

    // Reset in the middle of select's debounce, button held across release.
    i_btn_n = 7'b1111110;
    run(8);
    check("pre-rst o_right", int'(o_right), 1);
    i_btn_n = 7'b0111110;
    run(4);
    rst_n = 1'b0;
    #1;
    check("mid-rst o_right", int'(o_right), 0);
    check("mid-rst o_select", int'(o_select), 0);
    run(2);
    clr();
    rst_n = 1'b1;
    run(12);
    check("post-rst select count", ps, 1);
    check("post-rst select latency", fs, 7);
    check("post-rst o_right", int'(o_right), 1);
    i_btn_n = 7'h7F;
    run(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
